// File: rtl/mc_pkg.sv
// mc_pkg: shared widths and FSM state type for the 4x4 motion-compensation residual block.
package mc_pkg;
    localparam int PIX_W   = 8;
    localparam int BLK_DIM = 4;
    localparam int RES_W   = PIX_W + 1;
    localparam int SAD_W   = PIX_W + 4;

    typedef enum logic {
        FILL,
        OUTPUT
    } state_t;
endpackage

// File: rtl/mc_residual_row.sv
// mc_residual_row: combinational per-row residual (cur - pred) and sum of absolute residuals.
module mc_residual_row #(
    parameter int PIX_W   = mc_pkg::PIX_W,
    parameter int BLK_DIM = mc_pkg::BLK_DIM
) (
    input  logic [BLK_DIM*PIX_W-1:0]     cur,
    input  logic [BLK_DIM*PIX_W-1:0]     pred,
    output logic [BLK_DIM*(PIX_W+1)-1:0] res,
    output logic [PIX_W+3:0]             abs_sum
);
    localparam int RES_W = PIX_W + 1;
    localparam int SAD_W = PIX_W + 4;

    logic [PIX_W-1:0] mag [BLK_DIM];

    genvar g;
    for (g = 0; g < BLK_DIM; g++) begin : g_pix
        logic [RES_W-1:0] r;
        logic [RES_W-1:0] neg;
        // zero-extend both operands so the 9-bit difference is an exact two's-complement value
        assign r   = {1'b0, cur[g*PIX_W +: PIX_W]} - {1'b0, pred[g*PIX_W +: PIX_W]};
        assign neg = -r;
        assign mag[g] = r[RES_W-1] ? neg[PIX_W-1:0] : r[PIX_W-1:0];
        assign res[g*RES_W +: RES_W] = r;
    end

    always_comb begin
        abs_sum = '0;
        for (int i = 0; i < BLK_DIM; i++)
            abs_sum = abs_sum + SAD_W'(mag[i]);
    end
endmodule

// File: rtl/mc_residual_4x4.sv
// mc_residual_4x4: collects BLK_DIM row pairs into a residual block with its SAD,
// then holds the block until the downstream stage takes it.
module mc_residual_4x4 #(
    parameter int PIX_W   = mc_pkg::PIX_W,
    parameter int BLK_DIM = mc_pkg::BLK_DIM
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 src_valid,
    output logic                                 src_ready,
    input  logic [BLK_DIM*PIX_W-1:0]             cur_row,
    input  logic [BLK_DIM*PIX_W-1:0]             pred_row,
    output logic                                 dst_valid,
    input  logic                                 dst_ready,
    output logic [BLK_DIM*BLK_DIM*(PIX_W+1)-1:0] res_blk,
    output logic [PIX_W+3:0]                     sad
);
    localparam int RES_W = PIX_W + 1;
    localparam int ROW_W = BLK_DIM * RES_W;
    localparam int CNT_W = BLK_DIM > 1 ? $clog2(BLK_DIM) : 1;

    mc_pkg::state_t   state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [ROW_W-1:0] row_res;
    logic [PIX_W+3:0] row_sad;
    logic             take, give, last;

    mc_residual_row #(.PIX_W(PIX_W), .BLK_DIM(BLK_DIM)) u_row (
        .cur     (cur_row),
        .pred    (pred_row),
        .res     (row_res),
        .abs_sum (row_sad)
    );

    assign take = src_valid && src_ready;
    assign give = dst_valid && dst_ready;
    assign last = cnt == CNT_W'(BLK_DIM - 1);

    // src_ready is gated by reset so it reads 0 while reset is held
    always_comb begin
        state_nxt = state;
        src_ready = 1'b0;
        dst_valid = 1'b0;
        if (state == mc_pkg::FILL) begin
            src_ready = reset;
            if (src_valid && last)
                state_nxt = mc_pkg::OUTPUT;
        end else begin
            dst_valid = 1'b1;
            if (dst_ready)
                state_nxt = mc_pkg::FILL;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= mc_pkg::FILL;
            cnt     <= '0;
            sad     <= '0;
            res_blk <= '0;
        end else begin
            state <= state_nxt;
            if (take) begin
                res_blk[int'(cnt)*ROW_W +: ROW_W] <= row_res;
                cnt <= last ? '0 : cnt + 1'b1;
                sad <= sad + row_sad;
            end else if (give) begin
                sad <= '0;
            end
        end
    end
endmodule

// File: tb/tb_mc_residual_4x4.sv
// tb_mc_residual_4x4: randomized and directed blocks checked against an arithmetic reference model.
module tb_mc_residual_4x4;
    logic         clk = 1'b0, reset = 1'b0, src_valid = 1'b0, dst_ready = 1'b0;
    logic [31:0]  cur_row = '0, pred_row = '0;
    logic         src_ready, dst_valid;
    logic [143:0] res_blk;
    logic [11:0]  sad;
    int           checks = 0, errors = 0;
    byte unsigned cur_a [16];
    byte unsigned pred_a[16];

    mc_residual_4x4 dut (
        .clk       (clk),
        .reset     (reset),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .cur_row   (cur_row),
        .pred_row  (pred_row),
        .dst_valid (dst_valid),
        .dst_ready (dst_ready),
        .res_blk   (res_blk),
        .sad       (sad)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [143:0] got, input logic [143:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [143:0] ref_blk();
        logic [143:0] e = '0;
        for (int i = 0; i < 16; i++) begin
            int r;
            r = int'(cur_a[i]) - int'(pred_a[i]);
            e[i*9 +: 9] = r[8:0];
        end
        return e;
    endfunction

    function automatic int ref_sad();
        int s = 0;
        for (int i = 0; i < 16; i++) begin
            int r;
            r = int'(cur_a[i]) - int'(pred_a[i]);
            s += (r < 0) ? -r : r;
        end
        return s;
    endfunction

    task automatic set_block(input int mode, input byte unsigned c, input byte unsigned p);
        for (int i = 0; i < 16; i++) begin
            cur_a[i]  = (mode == 0) ? c : 8'($urandom);
            pred_a[i] = (mode == 0) ? p : 8'($urandom);
        end
    endtask

    // mode 0: src_valid always 1; 1: toggles 1,0,1,0; 2: random gaps
    task automatic fill(input int mode, input int rows);
        int row = 0;
        int cyc = 0;
        bit tog = 1'b1;
        while (row < rows && cyc < 100) begin
            @(negedge clk);
            cyc++;
            check("fill_dst_valid", dst_valid, 0);
            check("fill_src_ready", src_ready, 1);
            src_valid = (mode == 0) ? 1'b1 : (mode == 1) ? tog : ($urandom_range(99) >= 30);
            tog = !tog;
            dst_ready = 1'($urandom_range(1));
            for (int k = 0; k < 4; k++) begin
                cur_row[k*8 +: 8]  = src_valid ? cur_a[row*4+k]  : 8'($urandom);
                pred_row[k*8 +: 8] = src_valid ? pred_a[row*4+k] : 8'($urandom);
            end
            if (src_valid && src_ready) row++;
        end
        if (row < rows) check("fill_timeout", 0, 1);
        @(negedge clk);
        src_valid = 1'b0;
        dst_ready = 1'b0;
    endtask

    task automatic drain(input int hold);
        check("out_dst_valid", dst_valid, 1);
        check("out_src_ready", src_ready, 0);
        check("out_res_blk", res_blk, ref_blk());
        check("out_sad", sad, ref_sad());
        repeat (hold) begin
            src_valid = 1'b1;
            cur_row   = $urandom;
            pred_row  = $urandom;
            @(negedge clk);
            check("hold_src_ready", src_ready, 0);
            check("hold_dst_valid", dst_valid, 1);
            check("hold_res_blk", res_blk, ref_blk());
            check("hold_sad", sad, ref_sad());
        end
        src_valid = 1'b0;
        dst_ready = 1'b1;
        @(negedge clk);
        dst_ready = 1'b0;
        check("post_dst_valid", dst_valid, 0);
        check("post_src_ready", src_ready, 1);
        check("post_sad", sad, 0);
        check("post_res_stale", res_blk, ref_blk());
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_src_ready", src_ready, 0);
        check("rst_dst_valid", dst_valid, 0);
        check("rst_sad", sad, 0);
        check("rst_res_blk", res_blk, 0);
        reset = 1'b1;
        #1 check("rst_release_src_ready", src_ready, 1);

        set_block(0, 8'h80, 8'h80); fill(0, 4); drain(0);
        set_block(0, 8'h00, 8'hFF); fill(0, 4); drain(0);
        set_block(0, 8'hFF, 8'h00); fill(0, 4); drain(0);
        set_block(1, 0, 0);         fill(0, 4); drain(10);
        set_block(1, 0, 0);         fill(1, 4); drain(2);

        set_block(1, 0, 0); fill(0, 2);
        reset = 1'b0;
        #1;
        check("midrst_dst_valid", dst_valid, 0);
        check("midrst_src_ready", src_ready, 0);
        check("midrst_sad", sad, 0);
        check("midrst_res_blk", res_blk, 0);
        @(negedge clk);
        reset = 1'b1;
        set_block(1, 0, 0); fill(0, 4); drain(1);

        set_block(1, 0, 0); fill(0, 4);
        reset = 1'b0;
        #1 check("outrst_dst_valid", dst_valid, 0);
        @(negedge clk);
        reset = 1'b1;
        set_block(1, 0, 0); fill(2, 4); drain(0);

        for (int b = 0; b < 20; b++) begin
            set_block(1, 0, 0);
            fill(2, 4);
            drain($urandom_range(3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mc_residual_4x4.md
MC_RESIDUAL_4X4 -- requirements
Module: mc_residual_4x4

Interface
REQ-001 SHALL have parameter PIX_W, default 8: pixel bit width.
REQ-002 SHALL have parameter BLK_DIM, default 4: block edge, in pixels and rows.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset (asserted at 0).
REQ-005 SHALL have port src_valid, input, 1: upstream row pair present.
REQ-006 SHALL have port src_ready, output, 1: block accepts a row this cycle.
REQ-007 SHALL have port cur_row, input, BLK_DIM*PIX_W: current-frame row; pixel 0 in LSBs.
REQ-008 SHALL have port pred_row, input, BLK_DIM*PIX_W: motion-compensated prediction row, same packing.
REQ-009 SHALL have port dst_valid, output, 1: completed residual block presented.
REQ-010 SHALL have port dst_ready, input, 1: downstream transform stage accepts the block.
REQ-011 SHALL have port res_blk, output, BLK_DIM*BLK_DIM*(PIX_W+1): signed residuals, row-major; row 0 pixel 0 in LSBs.
REQ-012 SHALL have port sad, output, PIX_W+4: sum of absolute residuals of the presented block.

Function
REQ-013 SHALL transfer a row only on a cycle where src_valid and src_ready are both 1; src_valid with src_ready=0 has no effect.
REQ-014 SHALL compute residual[i] = cur[i] - pred[i] as a (PIX_W+1)-bit two's-complement value, range -255..+255; no saturation.
REQ-015 SHALL accumulate sad += sum of |residual[i]| over each accepted row; max 16*255 = 4080 fits without overflow.
REQ-016 SHALL use a 2-state FSM, FILL and OUTPUT, with reset state FILL.
REQ-017 In FILL, SHALL drive src_ready=1 and dst_valid=0.
REQ-018 In FILL, a row counter (0..BLK_DIM-1) SHALL select the res_blk row slot written on each transfer and then increment.
REQ-019 On the transfer with counter = BLK_DIM-1, SHALL wrap the counter to 0 and enter OUTPUT next cycle; dst_valid=1 on the cycle after the 4th row handshake (latency 1).
REQ-020 In OUTPUT, SHALL drive src_ready=0 and dst_valid=1, and hold res_blk and sad stable until handshake.
REQ-021 On dst_valid and dst_ready both 1, SHALL enter FILL next cycle with sad cleared to 0; minimum throughput one block per 5 cycles.
REQ-022 dst_ready while dst_valid=0 SHALL be ignored.
REQ-023 Gaps in src_valid mid-block SHALL stall the fill without losing accepted rows or SAD.
REQ-024 res_blk slots for rows not yet refilled SHALL retain stale data; only valid while dst_valid=1.

Reset
REQ-025 While reset=0, SHALL force: state FILL, row counter 0, sad 0, res_blk all 0, dst_valid 0, src_ready 0.
REQ-026 On the first cycle after reset deasserts, src_ready SHALL be 1.
REQ-027 Reset asserted mid-fill or during OUTPUT SHALL discard the partial or pending block; nothing is emitted for it.

Structure
REQ-028 PIX_W, RES_W (PIX_W+1), SAD_W (PIX_W+4), BLK_DIM and the state enum typedef SHALL live in shared package mc_pkg.
REQ-029 Per-row subtract and absolute-sum logic SHALL be one combinational sub-module, mc_residual_row, instantiated once.
REQ-030 The FSM, row counter, block register and SAD accumulator SHALL reside in mc_residual_4x4.

Verification
REQ-031 Fill 4 rows with cur=0x80 and pred=0x80 in all pixels, dst_ready=1 -> dst_valid on cycle 5, all residuals 0, sad 0, src_ready=1 on cycle 6.
REQ-032 All cur=0x00, pred=0xFF -> every residual 0x101 (-255), sad=4080; all cur=0xFF, pred=0x00 -> residuals 0x0FF, sad=4080.
REQ-033 dst_ready held 0 for 10 cycles after dst_valid, with src_valid=1 throughout -> src_ready=0, res_blk and sad unchanged, no row consumed.
REQ-034 src_valid toggled 1,0,1,0,... over 8 cycles -> exactly 4 rows accepted; dst_valid the cycle after the 4th handshake; sad equals the reference sum.
REQ-035 Reset pulsed low after 2 rows -> dst_valid 0, sad 0, counter 0; next 4 rows produce a block containing only post-reset data.
